// File: rtl/mult_div_unit.sv
// mult_div_unit -- Execute-stage multiply/divide unit.
//
// Holds the architectural HI/LO pair. A MULT/DIV-class op is computed at once
// when it is accepted, parked in hi_p/lo_p, and written to HI/LO only after
// the configured latency, so the rest of the pipeline sees a multi-cycle unit.
//
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB, op codes 7-9).
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (and MADD family), >= 1
//   DIV_CYCLES   busy cycles for DIV/DIVU, >= 1
// Ports:
//   clk          pipeline clock, rising edge
//   reset        synchronous active-high reset
//   E_MDOp[3:0]  op in Execute (0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                7 MADD,8 MADDU,9 MSUB; anything else is a NOP)
//   E_A, E_B     forwarded rs / rt operands
//   E_HI, E_LO   architectural HI / LO (registered)
//   E_MD_busy    registered, high while an operation is in flight
//   E_MD_hazard  combinational: start op present OR busy
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO,
   output logic        E_MD_busy,
   output logic        E_MD_hazard
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      hi, hi_n, lo, lo_n;
   logic [31:0]      hi_p, hi_p_n, lo_p, lo_p_n;
   logic             wr_p, wr_p_n;   // pending result is to be written at completion

   // ---------------- arithmetic, evaluated on the current operands ----------
   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   assign a_sx   = {{32{E_A[31]}}, E_A};
   assign b_sx   = {{32{E_B[31]}}, E_B};
   // Low 64 bits of the 64x64 product of sign-extended operands are the
   // signed 32x32 product.
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, E_A} * {32'd0, E_B};

   // Signed divide via magnitudes: avoids the -2^31 / -1 overflow corner in
   // a native signed divide and naturally gives LO=0x80000000, HI=0 there.
   logic        a_neg, b_neg, b_zero;
   logic [31:0] a_mag, b_mag, dvs_s, dvs_u;
   logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
   assign a_neg  = E_A[31];
   assign b_neg  = E_B[31];
   assign b_zero = (E_B == 32'd0);
   assign a_mag  = a_neg ? (32'd0 - E_A) : E_A;
   assign b_mag  = b_neg ? (32'd0 - E_B) : E_B;
   // Divisor forced to 1 on divide-by-zero so no X/undefined result is formed;
   // the result is discarded anyway.
   assign dvs_s  = b_zero ? 32'd1 : b_mag;
   assign dvs_u  = b_zero ? 32'd1 : E_B;
   assign uq_s   = a_mag / dvs_s;
   assign ur_s   = a_mag % dvs_s;
   assign q_s    = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
   assign r_s    = a_neg ? (32'd0 - ur_s) : ur_s;
   assign q_u    = E_A / dvs_u;
   assign r_u    = E_A % dvs_u;

`ifdef MDU_MADD_EN
   logic [63:0] acc, madd_s, madd_u, msub_s;
   assign acc    = {hi, lo};     // accumulate on HI/LO as of acceptance
   assign madd_s = acc + prod_s;
   assign madd_u = acc + prod_u;
   assign msub_s = acc - prod_s;
`endif

   // ---------------- start-op decode ----------------------------------------
   logic start_op;
   always_comb begin
      start_op = 1'b0;
      case (E_MDOp)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_op = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB:         start_op = 1'b1;
`endif
         default:                            start_op = 1'b0;
      endcase
   end

   // ---------------- state register -----------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         hi_p  <= '0;
         lo_p  <= '0;
         wr_p  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi    <= hi_n;
         lo    <= lo_n;
         hi_p  <= hi_p_n;
         lo_p  <= lo_p_n;
         wr_p  <= wr_p_n;
      end
   end

   // ---------------- next state / outputs -----------------------------------
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hi_n        = hi;
      lo_n        = lo;
      hi_p_n      = hi_p;
      lo_p_n      = lo_p;
      wr_p_n      = wr_p;
      E_MD_hazard = start_op || (state == S_BUSY);

      case (state)
         S_IDLE: begin
            case (E_MDOp)
               OP_MULT: begin
                  {hi_p_n, lo_p_n} = prod_s;
                  wr_p_n  = 1'b1;
                  cnt_n   = MULT_LOAD;
                  state_n = S_BUSY;
               end
               OP_MULTU: begin
                  {hi_p_n, lo_p_n} = prod_u;
                  wr_p_n  = 1'b1;
                  cnt_n   = MULT_LOAD;
                  state_n = S_BUSY;
               end
               OP_DIV: begin
                  hi_p_n  = r_s;
                  lo_p_n  = q_s;
                  wr_p_n  = !b_zero;
                  cnt_n   = DIV_LOAD;
                  state_n = S_BUSY;
               end
               OP_DIVU: begin
                  hi_p_n  = r_u;
                  lo_p_n  = q_u;
                  wr_p_n  = !b_zero;
                  cnt_n   = DIV_LOAD;
                  state_n = S_BUSY;
               end
`ifdef MDU_MADD_EN
               OP_MADD: begin
                  {hi_p_n, lo_p_n} = madd_s;
                  wr_p_n  = 1'b1;
                  cnt_n   = MULT_LOAD;
                  state_n = S_BUSY;
               end
               OP_MADDU: begin
                  {hi_p_n, lo_p_n} = madd_u;
                  wr_p_n  = 1'b1;
                  cnt_n   = MULT_LOAD;
                  state_n = S_BUSY;
               end
               OP_MSUB: begin
                  {hi_p_n, lo_p_n} = msub_s;
                  wr_p_n  = 1'b1;
                  cnt_n   = MULT_LOAD;
                  state_n = S_BUSY;
               end
`endif
               OP_MTHI: hi_n = E_A;
               OP_MTLO: lo_n = E_A;
               default: ;
            endcase
         end
         S_BUSY: begin
            // Ops arriving here are dropped; only the counter advances.
            if (cnt == '0) begin
               if (wr_p) begin
                  hi_n = hi_p;
                  lo_n = lo_p;
               end
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign E_HI      = hi;
   assign E_LO      = lo;
   assign E_MD_busy = (state == S_BUSY);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops,
// checked against an arithmetic reference model of HI/LO and busy length.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk, reset;
   logic [3:0]  E_MDOp;
   logic [31:0] E_A, E_B, E_HI, E_LO;
   logic        E_MD_busy, E_MD_hazard;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_hi = 0, m_lo = 0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
      .E_HI(E_HI), .E_LO(E_LO), .E_MD_busy(E_MD_busy), .E_MD_hazard(E_MD_hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: result of a start op given the current model HI/LO.
   task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int n, output logic [31:0] nh, output logic [31:0] nl);
      longint      sp;
      logic [63:0] r64, up;
      int          sa, sb;
      sa = a; sb = b;
      sp = longint'(sa) * longint'(sb);
      up = {32'd0, a} * {32'd0, b};
      nh = m_hi; nl = m_lo; n = MC;
      case (op)
         4'd1: begin r64 = sp; {nh, nl} = r64; end
         4'd2: {nh, nl} = up;
         4'd3: begin
            n = DC;
            if (b != 0) begin
               if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin nl = a; nh = 0; end
               else begin nl = sa / sb; nh = sa % sb; end
            end
         end
         4'd4: begin
            n = DC;
            if (b != 0) begin nl = a / b; nh = a % b; end
         end
         4'd7: begin r64 = {m_hi, m_lo} + sp; {nh, nl} = r64; end
         4'd8: {nh, nl} = {m_hi, m_lo} + up;
         4'd9: begin r64 = {m_hi, m_lo} - sp; {nh, nl} = r64; end
         default: ;
      endcase
   endtask

   // Entered just after a falling edge; leaves just after a falling edge with
   // the result visible, so a following call is accepted back-to-back.
   task automatic run_start(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input bit ign);
      int n;
      logic [31:0] nh, nl;
      model_op(op, a, b, n, nh, nl);
      E_MDOp = op; E_A = a; E_B = b;
      #1;
      chk({tag, "_hz_acc"}, E_MD_hazard, 1);
      chk({tag, "_busy_acc"}, E_MD_busy, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ign && i == 1) begin E_MDOp = 4'd3; E_A = $urandom; E_B = $urandom | 1; end
         else if (ign && i == 2) begin E_MDOp = 4'd6; E_A = $urandom; end
         else E_MDOp = 4'd0;
         #1;
         chk({tag, "_busy"}, E_MD_busy, 1);
         chk({tag, "_hz"}, E_MD_hazard, 1);
         chk({tag, "_hi_hold"}, E_HI, m_hi);
         chk({tag, "_lo_hold"}, E_LO, m_lo);
      end
      @(negedge clk);
      E_MDOp = 4'd0;
      #1;
      m_hi = nh; m_lo = nl;
      chk({tag, "_busy_done"}, E_MD_busy, 0);
      chk({tag, "_hz_done"}, E_MD_hazard, 0);
      chk({tag, "_hi"}, E_HI, m_hi);
      chk({tag, "_lo"}, E_LO, m_lo);
   endtask

   task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
      E_MDOp = op; E_A = a; E_B = $urandom;
      #1;
      chk({tag, "_hz"}, E_MD_hazard, 0);
      chk({tag, "_busy"}, E_MD_busy, 0);
      @(negedge clk);
      E_MDOp = 4'd0;
      #1;
      if (op == 4'd5) m_hi = a; else m_lo = a;
      chk({tag, "_hi"}, E_HI, m_hi);
      chk({tag, "_lo"}, E_LO, m_lo);
      chk({tag, "_busy_after"}, E_MD_busy, 0);
   endtask

   initial begin
      int nops, k;
      logic [31:0] a, b;
      reset = 1'b1; E_MDOp = 0; E_A = 0; E_B = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_hi", E_HI, 0);
      chk("rst_lo", E_LO, 0);
      chk("rst_busy", E_MD_busy, 0);
      chk("rst_hz", E_MD_hazard, 0);

      run_start("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 0);
      chk("mult_hi_const", E_HI, 32'hFFFFFFFF);
      chk("mult_lo_const", E_LO, 32'hFFFFFFFA);
      run_start("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 0);
      chk("multu_hi_const", E_HI, 32'h00000002);
      chk("multu_lo_const", E_LO, 32'hFFFFFFFA);
      run_start("div", 4'd3, 32'hFFFFFFF9, 32'd2, 0);
      chk("div_lo_const", E_LO, 32'hFFFFFFFD);
      chk("div_hi_const", E_HI, 32'hFFFFFFFF);
      run_start("divu0", 4'd4, 32'd7, 32'd0, 0);
      chk("divu0_hi_const", E_HI, 32'hFFFFFFFF);
      run_start("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("divovf_lo_const", E_LO, 32'h80000000);
      chk("divovf_hi_const", E_HI, 32'h0);

      run_mt("mthi", 4'd5, 32'h12345678);
      run_mt("mtlo", 4'd6, 32'h9ABCDEF0);
      chk("mt_hi_const", E_HI, 32'h12345678);
      chk("mt_lo_const", E_LO, 32'h9ABCDEF0);

      run_start("ign", 4'd1, 32'd1234, 32'd5678, 1);
      chk("ign_lo_const", E_LO, 32'd7006652);

      run_mt("mthi0", 4'd5, 32'h0);
      run_mt("mtlofull", 4'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      run_start("maddu", 4'd8, 32'd1, 32'd1, 0);
      chk("maddu_hi_const", E_HI, 32'd1);
      chk("maddu_lo_const", E_LO, 32'd0);
      nops = 9;
`else
      E_MDOp = 4'd8; E_A = 32'd1; E_B = 32'd1;
      #1;
      chk("nomadd_hz", E_MD_hazard, 0);
      @(negedge clk);
      E_MDOp = 4'd0;
      #1;
      chk("nomadd_busy", E_MD_busy, 0);
      chk("nomadd_hi", E_HI, 32'h0);
      chk("nomadd_lo", E_LO, 32'hFFFFFFFF);
      nops = 6;
`endif

      for (int it = 0; it < 40; it++) begin
         k = $urandom_range(1, nops);
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
         if (k == 5 || k == 6) run_mt("rnd_mt", 4'(k), a);
         else run_start("rnd", 4'(k), a, b, $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of a divide: result must be discarded.
      E_MDOp = 4'd3; E_A = 32'd100; E_B = 32'd7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         E_MDOp = 4'd0;
         if (i == 3) reset = 1'b1;
         #1;
         if (i < 3) chk("rstmid_busy", E_MD_busy, 1);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_hi = 0; m_lo = 0;
      chk("rstmid_busy0", E_MD_busy, 0);
      chk("rstmid_hi", E_HI, 0);
      chk("rstmid_lo", E_LO, 0);
      for (int i = 0; i < DC + 2; i++) begin
         @(negedge clk);
         #1;
         chk("rstmid_hi_stay", E_HI, 0);
         chk("rstmid_lo_stay", E_LO, 0);
         chk("rstmid_busy_stay", E_MD_busy, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
